// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer/decoder family.
// Holds the gesture state encoding and the default 50 MHz timing thresholds.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } key_state_t;

  localparam int DEF_LONG_CNT   = 50_000_000;
  localparam int DEF_DCLICK_CNT = 15_000_000;
  localparam int DEF_REPEAT_CNT = 5_000_000;
  localparam int DEF_CNT_W      = 26;

endpackage

// File: rtl/key_event_decoder.sv
// Classifies debounced key press/release pulses into short, long, repeat and
// double-click single-cycle events, with one shared cycle counter.
//
// state  | meaning
// IDLE   | key up, no gesture in progress
// PRESS1 | first press held, timing toward long_press
// WAIT2  | released, waiting for a second press within the double-click window
// PRESS2 | second press held, double_click fires on its release
// LONG   | long press reached, emitting key_repeat every REPEAT_CNT cycles
module key_event_decoder
  import key_pkg::*;
#(
  parameter int LONG_CNT   = DEF_LONG_CNT,
  parameter int DCLICK_CNT = DEF_DCLICK_CNT,
  parameter int REPEAT_CNT = DEF_REPEAT_CNT,
  parameter bit DCLICK_EN  = 1'b1,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic key_press,
  input  logic key_release,
  output logic short_press,
  output logic long_press,
  output logic key_repeat,
  output logic double_click,
  output logic key_held
);

  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] DCLICK_TC = CNT_W'(DCLICK_CNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CNT - 1);

  key_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_press;
  logic             w_release;

  // A press and release in the same cycle carry no usable meaning; drop both.
  assign w_press   = key_press & ~key_release;
  assign w_release = key_release & ~key_press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      key_repeat   <= 1'b0;
      double_click <= 1'b0;
      key_held     <= 1'b0;
    end else begin
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      key_repeat   <= 1'b0;
      double_click <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_press) begin
            r_state  <= PRESS1;
            r_cnt    <= '0;
            key_held <= 1'b1;
          end
        end
        PRESS1: begin
          // Release is checked first so it wins over a coincident long timeout.
          if (w_release) begin
            r_cnt    <= '0;
            key_held <= 1'b0;
            if (DCLICK_EN) begin
              r_state <= WAIT2;
            end else begin
              short_press <= 1'b1;
              r_state     <= IDLE;
            end
          end else if (r_cnt == LONG_TC) begin
            long_press <= 1'b1;
            r_state    <= LONG;
            r_cnt      <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        LONG: begin
          if (w_release) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            key_held <= 1'b0;
          end else if (r_cnt == REPEAT_TC) begin
            key_repeat <= 1'b1;
            r_cnt      <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT2: begin
          if (w_press) begin
            r_state  <= PRESS2;
            r_cnt    <= '0;
            key_held <= 1'b1;
          end else if (r_cnt == DCLICK_TC) begin
            short_press <= 1'b1;
            r_state     <= IDLE;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PRESS2: begin
          if (w_release) begin
            double_click <= 1'b1;
            r_state      <= IDLE;
            key_held     <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_cnt    <= '0;
          key_held <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Randomized and directed bench for key_event_decoder (double-click enabled and
// disabled instances), checked against a timestamp-based gesture model.
module tb_key_event_decoder;

  localparam int LONG_CNT   = 20;
  localparam int DCLICK_CNT = 8;
  localparam int REPEAT_CNT = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_press = 1'b0;
  logic key_release = 1'b0;
  logic sp1, lp1, rp1, dc1, kh1;
  logic sp0, lp0, rp0, dc0, kh0;

  int n_chk = 0;
  int n_pass = 0;
  int gt = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  key_event_decoder #(
    .LONG_CNT(LONG_CNT), .DCLICK_CNT(DCLICK_CNT), .REPEAT_CNT(REPEAT_CNT),
    .DCLICK_EN(1'b1), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .key_press(key_press), .key_release(key_release),
    .short_press(sp1), .long_press(lp1), .key_repeat(rp1),
    .double_click(dc1), .key_held(kh1)
  );

  key_event_decoder #(
    .LONG_CNT(LONG_CNT), .DCLICK_CNT(DCLICK_CNT), .REPEAT_CNT(REPEAT_CNT),
    .DCLICK_EN(1'b0), .CNT_W(8)
  ) dut_nd (
    .clk(clk), .rst(rst), .key_press(key_press), .key_release(key_release),
    .short_press(sp0), .long_press(lp0), .key_repeat(rp0),
    .double_click(dc0), .key_held(kh0)
  );

  // Gesture model: timestamps of the events that matter, -1 when absent.
  typedef struct {
    int held_since;
    int gap_since;
    int long_at;
    bit second;
  } mdl_t;

  mdl_t m1, m0;
  logic [4:0] e1, e0;  // {held, short, long, repeat, dclick}

  function automatic mdl_t mreset();
    mdl_t m;
    m.held_since = -1;
    m.gap_since  = -1;
    m.long_at    = -1;
    m.second     = 1'b0;
    return m;
  endfunction

  task automatic mstep(input mdl_t mi, input bit en, input bit p, input bit r,
                       input int t, output mdl_t mo, output logic [4:0] ev);
    bit pp, rr;
    pp = p && !r;
    rr = r && !p;
    mo = mi;
    ev = '0;
    if (mo.long_at >= 0) begin
      if (rr) mo = mreset();
      else if ((t - mo.long_at) % REPEAT_CNT == 0) ev[1] = 1'b1;
    end else if (mo.held_since >= 0 && !mo.second) begin
      if (rr) begin
        mo.held_since = -1;
        if (en) mo.gap_since = t;
        else ev[3] = 1'b1;
      end else if (t - mo.held_since == LONG_CNT) begin
        ev[2] = 1'b1;
        mo.long_at = t;
      end
    end else if (mo.gap_since >= 0) begin
      if (pp) begin
        mo.held_since = t;
        mo.second = 1'b1;
        mo.gap_since = -1;
      end else if (t - mo.gap_since == DCLICK_CNT) begin
        ev[3] = 1'b1;
        mo.gap_since = -1;
      end
    end else if (mo.second) begin
      if (rr) begin
        ev[0] = 1'b1;
        mo = mreset();
      end
    end else if (pp) begin
      mo.held_since = t;
    end
    ev[4] = (mo.held_since >= 0);
  endtask

  function automatic logic [4:0] obs1();
    return {kh1, sp1, lp1, rp1, dc1};
  endfunction

  function automatic logic [4:0] obs0();
    return {kh0, sp0, lp0, rp0, dc0};
  endfunction

  // Drive one cycle of inputs; afterwards cyc names the cycle now visible.
  task automatic step(input bit p, input bit r);
    mdl_t n1, n0;
    @(negedge clk);
    key_press = p;
    key_release = r;
    @(posedge clk);
    mstep(m1, 1'b1, p, r, gt, n1, e1);
    mstep(m0, 1'b0, p, r, gt, n0, e0);
    m1 = n1;
    m0 = n0;
    gt++;
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    n_chk++;
    if (obs1() !== 5'b0 || obs0() !== 5'b0)
      $display("FAIL reset_state got=%b/%b want=00000", obs1(), obs0());
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    m1 = mreset();
    m0 = mreset();
    e1 = '0;
    e0 = '0;
  endtask

  task automatic test_short();
    int sp_cyc = -1;
    int sp_n = 0;
    cyc = 0;
    for (int c = 0; c < 24; c++) begin
      step(c == 0, c == 5);
      n_chk++;
      if (obs1() !== e1) $display("FAIL short_model cyc=%0d got=%b want=%b", cyc, obs1(), e1);
      else n_pass++;
      n_chk++;
      if (kh1 !== (cyc >= 1 && cyc <= 5)) $display("FAIL short_held cyc=%0d got=%b", cyc, kh1);
      else n_pass++;
      if (sp1) begin sp_cyc = cyc; sp_n++; end
    end
    n_chk++;
    if (sp_cyc != 14 || sp_n != 1) $display("FAIL short_cycle got=%0d n=%0d want=14 n=1", sp_cyc, sp_n);
    else n_pass++;
  endtask

  task automatic test_double_click();
    int dc_cyc = -1;
    int sp_n = 0;
    cyc = 0;
    for (int c = 0; c < 24; c++) begin
      step(c == 0 || c == 6, c == 3 || c == 9);
      n_chk++;
      if (obs1() !== e1) $display("FAIL dclick_model cyc=%0d got=%b want=%b", cyc, obs1(), e1);
      else n_pass++;
      if (dc1) dc_cyc = cyc;
      if (sp1) sp_n++;
    end
    n_chk++;
    if (dc_cyc != 10 || sp_n != 0) $display("FAIL dclick_cycle got=%0d short=%0d want=10 short=0", dc_cyc, sp_n);
    else n_pass++;
  endtask

  task automatic test_long_repeat();
    int lp_cyc = -1;
    int rp_seen[$];
    int sp_n = 0;
    int fall = -1;
    cyc = 0;
    for (int c = 0; c < 56; c++) begin
      step(c == 0, c == 40);
      n_chk++;
      if (obs1() !== e1) $display("FAIL long_model cyc=%0d got=%b want=%b", cyc, obs1(), e1);
      else n_pass++;
      if (lp1) lp_cyc = cyc;
      if (rp1) rp_seen.push_back(cyc);
      if (sp1) sp_n++;
      if (!kh1 && fall < 0 && cyc > 1) fall = cyc;
    end
    n_chk++;
    if (lp_cyc != 21) $display("FAIL long_cycle got=%0d want=21", lp_cyc);
    else n_pass++;
    n_chk++;
    if (rp_seen.size() != 3 || rp_seen[0] != 26 || rp_seen[1] != 31 || rp_seen[2] != 36)
      $display("FAIL repeat_cycles got_n=%0d want=26,31,36", rp_seen.size());
    else n_pass++;
    n_chk++;
    if (fall != 41 || sp_n != 0) $display("FAIL long_release fall=%0d short=%0d want=41 short=0", fall, sp_n);
    else n_pass++;
  endtask

  task automatic test_priority();
    int sp_cyc = -1;
    int lp_n = 0;
    int dc_cyc = -1;
    int sp_n = 0;
    cyc = 0;
    for (int c = 0; c < 36; c++) begin
      step(c == 0, c == 20);
      n_chk++;
      if (obs1() !== e1) $display("FAIL prio_rel_model cyc=%0d got=%b want=%b", cyc, obs1(), e1);
      else n_pass++;
      if (sp1) sp_cyc = cyc;
      if (lp1) lp_n++;
    end
    n_chk++;
    if (sp_cyc != 29 || lp_n != 0) $display("FAIL prio_release short=%0d long=%0d want=29 long=0", sp_cyc, lp_n);
    else n_pass++;
    cyc = 0;
    for (int c = 0; c < 20; c++) begin
      step(c == 0 || c == 11, c == 3 || c == 13);
      n_chk++;
      if (obs1() !== e1) $display("FAIL prio_press_model cyc=%0d got=%b want=%b", cyc, obs1(), e1);
      else n_pass++;
      if (dc1) dc_cyc = cyc;
      if (sp1) sp_n++;
    end
    n_chk++;
    if (dc_cyc != 14 || sp_n != 0) $display("FAIL prio_press dclick=%0d short=%0d want=14 short=0", dc_cyc, sp_n);
    else n_pass++;
  endtask

  task automatic test_no_dclick();
    int sp_cyc = -1;
    int sp_n = 0;
    int dc_n = 0;
    cyc = 0;
    for (int c = 0; c < 16; c++) begin
      step(c == 0 || c == 6, c == 3 || c == 8);
      n_chk++;
      if (obs0() !== e0) $display("FAIL nodc_model cyc=%0d got=%b want=%b", cyc, obs0(), e0);
      else n_pass++;
      if (sp0 && sp_cyc < 0) sp_cyc = cyc;
      if (sp0) sp_n++;
      if (dc0) dc_n++;
    end
    n_chk++;
    if (sp_cyc != 4 || sp_n != 2 || dc_n != 0)
      $display("FAIL nodc_events first=%0d n=%0d dclick=%0d want=4 n=2 dclick=0", sp_cyc, sp_n, dc_n);
    else n_pass++;
    for (int c = 0; c < 12; c++) step(1'b0, 1'b0);
  endtask

  task automatic test_mid_reset();
    int ev_n = 0;
    cyc = 0;
    for (int c = 0; c < 12; c++) step(c == 0, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (obs1() !== 5'b0 || obs0() !== 5'b0)
      $display("FAIL mid_reset got=%b/%b want=00000", obs1(), obs0());
    else n_pass++;
    m1 = mreset();
    m0 = mreset();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step(1'b0, c == 1);
      n_chk++;
      if (obs1() !== e1 || obs0() !== e0)
        $display("FAIL post_reset_model cyc=%0d got=%b/%b want=%b/%b", cyc, obs1(), obs0(), e1, e0);
      else n_pass++;
      if (obs1() != 5'b0 || obs0() != 5'b0) ev_n++;
    end
    n_chk++;
    if (ev_n != 0) $display("FAIL stray_release activity=%0d want=0", ev_n);
    else n_pass++;
  endtask

  task automatic test_random();
    int pr, rr;
    bit p, r;
    for (int seg = 0; seg < 40; seg++) begin
      case ($urandom_range(2, 0))
        0: pr = 3;
        1: pr = 12;
        default: pr = 45;
      endcase
      for (int c = 0; c < 60; c++) begin
        rr = $urandom_range(pr - 1, 0);
        p = ($urandom_range(pr - 1, 0) == 0);
        r = (rr == 0);
        step(p, r);
        n_chk++;
        if (obs1() !== e1 || obs0() !== e0)
          $display("FAIL random_model t=%0d got=%b/%b want=%b/%b", gt, obs1(), obs0(), e1, e0);
        else n_pass++;
      end
    end
    step(1'b0, 1'b1);
    for (int c = 0; c < 20; c++) step(1'b0, 1'b0);
  endtask

  initial begin
    m1 = mreset();
    m0 = mreset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_short();
    test_double_click();
    test_long_repeat();
    test_priority();
    test_no_dclick();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
